// File: rtl/br_predictor_gshare.sv
// rtl/br_predictor_gshare.sv - gshare direction predictor with speculative history and indirect-target buffer
module br_predictor_gshare #(
  parameter int BHT_IDX_W = 8,
  parameter int GHR_W     = 8,
  parameter int CTR_W     = 2,
  parameter int BTB_IDX_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              valid_from_inst_fetcher,
  input  logic [31:0]       pc_from_inst_fetcher,
  input  logic [31:0]       inst_from_inst_fetcher,
  output logic [31:0]       next_pc_to_inst_fetcher,
  output logic              pred_taken_to_inst_fetcher,
  output logic [GHR_W-1:0]  ghr_to_inst_fetcher,
  input  logic              valid_from_rob_bus,
  input  logic [31:0]       pc_from_rob_bus,
  input  logic              is_br_from_rob_bus,
  input  logic              is_jalr_from_rob_bus,
  input  logic              is_taken_from_rob_bus,
  input  logic [31:0]       target_from_rob_bus,
  input  logic [GHR_W-1:0]  ghr_from_rob_bus,
  input  logic              mispredict_from_rob_bus
);

  localparam int BHT_N = 1 << BHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_W = 30 - BTB_IDX_W;

  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);

  logic [CTR_W-1:0] pht_q       [BHT_N];
  logic [CTR_W-1:0] pht_d       [BHT_N];
  logic             btb_valid_q [BTB_N];
  logic             btb_valid_d [BTB_N];
  logic [TAG_W-1:0] btb_tag_q   [BTB_N];
  logic [TAG_W-1:0] btb_tag_d   [BTB_N];
  logic [31:0]      btb_tgt_q   [BTB_N];
  logic [31:0]      btb_tgt_d   [BTB_N];
  logic [GHR_W-1:0] ghr_q;
  logic [GHR_W-1:0] ghr_d;

  function automatic logic [GHR_W-1:0] ghr_push(input logic [GHR_W-1:0] h, input logic b);
    return (h << 1) | GHR_W'(b);
  endfunction

  // Fetch-side decode and lookup
  logic [6:0]           f_opcode;
  logic                 f_is_jal;
  logic                 f_is_br;
  logic                 f_is_jalr;
  logic [31:0]          f_j_imm;
  logic [31:0]          f_b_imm;
  logic [BHT_IDX_W-1:0] f_bht_idx;
  logic [CTR_W-1:0]     f_ctr;
  logic                 f_br_taken;
  logic [BTB_IDX_W-1:0] f_btb_idx;
  logic [TAG_W-1:0]     f_btb_tag;
  logic                 f_btb_hit;

  assign f_opcode   = inst_from_inst_fetcher[6:0];
  assign f_is_jal   = (f_opcode == OP_JAL);
  assign f_is_br    = (f_opcode == OP_BR);
  assign f_is_jalr  = (f_opcode == OP_JALR);

  assign f_j_imm = {{12{inst_from_inst_fetcher[31]}}, inst_from_inst_fetcher[19:12],
                    inst_from_inst_fetcher[20], inst_from_inst_fetcher[30:21], 1'b0};
  assign f_b_imm = {{20{inst_from_inst_fetcher[31]}}, inst_from_inst_fetcher[7],
                    inst_from_inst_fetcher[30:25], inst_from_inst_fetcher[11:8], 1'b0};

  assign f_bht_idx  = pc_from_inst_fetcher[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr_q);
  assign f_ctr      = pht_q[f_bht_idx];
  assign f_br_taken = f_ctr[CTR_W-1];

  assign f_btb_idx  = pc_from_inst_fetcher[BTB_IDX_W+1:2];
  assign f_btb_tag  = pc_from_inst_fetcher[31:BTB_IDX_W+2];
  assign f_btb_hit  = btb_valid_q[f_btb_idx] && (btb_tag_q[f_btb_idx] == f_btb_tag);

  always_comb begin
    next_pc_to_inst_fetcher    = pc_from_inst_fetcher + 32'd4;
    pred_taken_to_inst_fetcher = 1'b0;
    if (f_is_jal) begin
      next_pc_to_inst_fetcher    = pc_from_inst_fetcher + f_j_imm;
      pred_taken_to_inst_fetcher = 1'b1;
    end else if (f_is_br && f_br_taken) begin
      next_pc_to_inst_fetcher    = pc_from_inst_fetcher + f_b_imm;
      pred_taken_to_inst_fetcher = 1'b1;
    end else if (f_is_jalr && f_btb_hit) begin
      next_pc_to_inst_fetcher    = btb_tgt_q[f_btb_idx];
      pred_taken_to_inst_fetcher = 1'b1;
    end
  end

  assign ghr_to_inst_fetcher = ghr_q;

  // Commit-side indexing uses the snapshot so training lands on the predicting entry
  logic [BHT_IDX_W-1:0] r_bht_idx;
  logic [CTR_W-1:0]     r_ctr;
  logic [BTB_IDX_W-1:0] r_btb_idx;
  logic [TAG_W-1:0]     r_btb_tag;
  logic                 unused_rob_pc_lo;

  assign r_bht_idx        = pc_from_rob_bus[BHT_IDX_W+1:2] ^ BHT_IDX_W'(ghr_from_rob_bus);
  assign r_ctr            = pht_q[r_bht_idx];
  assign r_btb_idx        = pc_from_rob_bus[BTB_IDX_W+1:2];
  assign r_btb_tag        = pc_from_rob_bus[31:BTB_IDX_W+2];
  assign unused_rob_pc_lo = ^pc_from_rob_bus[1:0];

  always_comb begin
    for (int i = 0; i < BHT_N; i++) begin
      pht_d[i] = pht_q[i];
    end
    for (int i = 0; i < BTB_N; i++) begin
      btb_valid_d[i] = btb_valid_q[i];
      btb_tag_d[i]   = btb_tag_q[i];
      btb_tgt_d[i]   = btb_tgt_q[i];
    end
    ghr_d = ghr_q;

    if (rst) begin
      for (int i = 0; i < BHT_N; i++) begin
        pht_d[i] = CTR_INIT;
      end
      for (int i = 0; i < BTB_N; i++) begin
        btb_valid_d[i] = 1'b0;
      end
      ghr_d = '0;
    end else if (rdy) begin
      if (valid_from_rob_bus && is_br_from_rob_bus) begin
        if (is_taken_from_rob_bus) begin
          pht_d[r_bht_idx] = (r_ctr == CTR_MAX) ? r_ctr : r_ctr + CTR_ONE;
        end else begin
          pht_d[r_bht_idx] = (r_ctr == '0) ? r_ctr : r_ctr - CTR_ONE;
        end
      end
      if (valid_from_rob_bus && is_jalr_from_rob_bus) begin
        btb_valid_d[r_btb_idx] = 1'b1;
        btb_tag_d[r_btb_idx]   = r_btb_tag;
        btb_tgt_d[r_btb_idx]   = target_from_rob_bus;
      end
      // Recovery wins over the speculative shift of a same-cycle fetch
      if (valid_from_rob_bus && mispredict_from_rob_bus) begin
        ghr_d = is_br_from_rob_bus ? ghr_push(ghr_from_rob_bus, is_taken_from_rob_bus)
                                   : ghr_from_rob_bus;
      end else if (valid_from_inst_fetcher && f_is_br) begin
        ghr_d = ghr_push(ghr_q, f_br_taken);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BHT_N; i++) begin
      pht_q[i] <= pht_d[i];
    end
    for (int i = 0; i < BTB_N; i++) begin
      btb_valid_q[i] <= btb_valid_d[i];
      btb_tag_q[i]   <= btb_tag_d[i];
      btb_tgt_q[i]   <= btb_tgt_d[i];
    end
    ghr_q <= ghr_d;
  end

endmodule

// File: tb/tb_br_predictor_gshare.sv
// tb/tb_br_predictor_gshare.sv - directed plus randomized bench for br_predictor_gshare
module tb_br_predictor_gshare;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        fv;
  logic [31:0] fpc;
  logic [31:0] finst;
  logic [31:0] next_pc;
  logic        pred_taken;
  logic [7:0]  ghr_out;
  logic        rv;
  logic [31:0] rpc;
  logic        rbr;
  logic        rjalr;
  logic        rtk;
  logic [31:0] rtgt;
  logic [7:0]  rghr;
  logic        rmp;

  br_predictor_gshare #(
    .BHT_IDX_W(8), .GHR_W(8), .CTR_W(2), .BTB_IDX_W(4)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .valid_from_inst_fetcher(fv), .pc_from_inst_fetcher(fpc), .inst_from_inst_fetcher(finst),
    .next_pc_to_inst_fetcher(next_pc), .pred_taken_to_inst_fetcher(pred_taken),
    .ghr_to_inst_fetcher(ghr_out),
    .valid_from_rob_bus(rv), .pc_from_rob_bus(rpc), .is_br_from_rob_bus(rbr),
    .is_jalr_from_rob_bus(rjalr), .is_taken_from_rob_bus(rtk), .target_from_rob_bus(rtgt),
    .ghr_from_rob_bus(rghr), .mispredict_from_rob_bus(rmp)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  bit cur_rdy    = 1'b1;

  // Reference model state
  int          m_ctr  [256];
  int          m_ghr;
  bit          m_bv   [16];
  int unsigned m_btag [16];
  logic [31:0] m_btgt [16];

  localparam logic [31:0] B16  = 32'h0000_0863;
  localparam logic [31:0] JALR = 32'h0000_0067;

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) m_ctr[i] = 1;
    for (int i = 0; i < 16; i++) m_bv[i] = 1'b0;
    m_ghr = 0;
  endfunction

  function automatic void model_pred(input logic [31:0] pc, input logic [31:0] inst,
                                     output logic [31:0] npc, output logic tk);
    int unsigned op  = inst & 32'h7f;
    int unsigned idx = ((pc >> 2) ^ m_ghr) % 256;
    int unsigned bi  = (pc >> 2) % 16;
    int signed jimm  = (inst[31] ? -1048576 : 0) + int'(inst[19:12]) * 4096
                     + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
    int signed bimm  = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048
                     + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
    npc = pc + 32'd4;
    tk  = 1'b0;
    if (op == 32'h6f) begin
      npc = pc + jimm; tk = 1'b1;
    end else if (op == 32'h63 && m_ctr[idx] >= 2) begin
      npc = pc + bimm; tk = 1'b1;
    end else if (op == 32'h67 && m_bv[bi] && m_btag[bi] == (pc >> 6)) begin
      npc = m_btgt[bi]; tk = 1'b1;
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit y, input bit v, input logic [31:0] pc,
                      input logic [31:0] inst, input bit cv, input logic [31:0] cpc,
                      input bit cbr, input bit cjalr, input bit ctk, input logic [31:0] ctgt,
                      input int cghr, input bit cmp);
    logic [31:0] enp;
    logic        etk;
    int unsigned ci;
    @(negedge clk);
    rst = r; rdy = y; fv = v; fpc = pc; finst = inst;
    rv = cv; rpc = cpc; rbr = cbr; rjalr = cjalr; rtk = ctk; rtgt = ctgt;
    rghr = 8'(cghr); rmp = cmp;
    #1;
    model_pred(pc, inst, enp, etk);
    check("ghr_out", 32'(ghr_out), 32'(m_ghr));
    if (v) begin
      check("next_pc", next_pc, enp);
      check("pred_taken", 32'(pred_taken), 32'(etk));
    end
    if (r) begin
      model_reset();
    end else if (y) begin
      if (cv && cbr) begin
        ci = ((cpc >> 2) ^ cghr) % 256;
        if (ctk) m_ctr[ci] = (m_ctr[ci] < 3) ? m_ctr[ci] + 1 : 3;
        else     m_ctr[ci] = (m_ctr[ci] > 0) ? m_ctr[ci] - 1 : 0;
      end
      if (cv && cjalr) begin
        ci = (cpc >> 2) % 16;
        m_bv[ci] = 1'b1; m_btag[ci] = cpc >> 6; m_btgt[ci] = ctgt;
      end
      if (cv && cmp) m_ghr = cbr ? ((cghr * 2) + int'(ctk)) % 256 : cghr;
      else if (v && (inst & 32'h7f) == 32'h63) m_ghr = ((m_ghr * 2) + int'(etk)) % 256;
    end
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
    step(0, cur_rdy, 1, pc, inst, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic commit_br(input logic [31:0] pc, input int g, input bit tk);
    step(0, cur_rdy, 0, 0, 0, 1, pc, 1, 0, tk, 0, g, 0);
  endtask
  task automatic commit_jalr(input logic [31:0] pc, input logic [31:0] tgt);
    step(0, cur_rdy, 0, 0, 0, 1, pc, 0, 1, 0, tgt, 0, 0);
  endtask
  task automatic set_ghr(input int g);
    step(0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, g, 1);
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 15) == 0) return $urandom() & 32'hffff_fffc;
    return 32'h0000_1000 | ($urandom_range(0, 7) << 6) | ($urandom_range(0, 15) << 2);
  endfunction

  initial begin
    logic [31:0] pc;
    logic [31:0] inst;
    rst = 1'b1; rdy = 1'b1; fv = 1'b0; fpc = '0; finst = '0;
    rv = 1'b0; rpc = '0; rbr = 1'b0; rjalr = 1'b0; rtk = 1'b0; rtgt = '0; rghr = '0; rmp = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    step(1, 1, 1, 32'h100, B16, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset defaults
    fetch(32'h100, B16);
    check("rst_npc", next_pc, 32'h104);
    check("rst_taken", 32'(pred_taken), 32'h0);
    check("rst_ghr", 32'(ghr_out), 32'h0);

    // Counter training and saturation at both ends
    commit_br(32'h100, 0, 1); commit_br(32'h100, 0, 1);
    fetch(32'h100, B16);
    check("train_npc", next_pc, 32'h110);
    set_ghr(0);
    commit_br(32'h100, 0, 1); commit_br(32'h100, 0, 1);
    fetch(32'h100, B16);
    check("sat_hi_npc", next_pc, 32'h110);
    set_ghr(0);
    repeat (5) commit_br(32'h100, 0, 0);
    commit_br(32'h100, 0, 1);
    fetch(32'h100, B16);
    check("sat_lo_npc", next_pc, 32'h104);

    // History shift and history-based indexing
    commit_br(32'h180, 0, 1); commit_br(32'h180, 0, 1);
    fetch(32'h180, B16);
    fetch(32'h184, B16);
    check("ghr_one", 32'(ghr_out), 32'h1);
    fetch(32'h100, B16);
    check("ghr_two", 32'(ghr_out), 32'h3);
    check("idx43_npc", next_pc, 32'h104);
    commit_br(32'h100, 3, 1); commit_br(32'h100, 3, 1);
    set_ghr(3);
    fetch(32'h100, B16);
    check("idx43_trained", next_pc, 32'h110);
    set_ghr(0);
    fetch(32'h100, B16);
    check("idx40_untouched", next_pc, 32'h104);

    // Mispredict recovery overriding a same-cycle fetch shift
    step(0, 1, 1, 32'h180, B16, 1, 32'h300, 1, 0, 0, 0, 5, 1);
    check("recov_fetch_taken", 32'(pred_taken), 32'h1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("recov_ghr", 32'(ghr_out), 32'h0a);

    // Indirect targets through the BTB
    fetch(32'h200, JALR);
    check("jalr_cold", next_pc, 32'h204);
    commit_jalr(32'h200, 32'h3000);
    fetch(32'h200, JALR);
    check("jalr_hit", next_pc, 32'h3000);
    fetch(32'h240, JALR);
    check("jalr_alias", next_pc, 32'h244);

    // Freeze
    set_ghr(0);
    cur_rdy = 1'b0;
    repeat (3) commit_br(32'h100, 0, 1);
    fetch(32'h180, B16);
    fetch(32'h180, B16);
    cur_rdy = 1'b1;
    fetch(32'h100, B16);
    check("freeze_ghr", 32'(ghr_out), 32'h0);
    check("freeze_ctr", next_pc, 32'h104);

    // Reset in the middle of training
    commit_br(32'h100, 0, 1); commit_br(32'h100, 0, 1);
    set_ghr(8'h55);
    step(1, 1, 0, 0, 0, 1, 32'h100, 1, 0, 1, 0, 0, 0);
    fetch(32'h100, B16);
    check("midrst_ghr", 32'(ghr_out), 32'h0);
    check("midrst_npc", next_pc, 32'h104);

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      pc = rand_pc();
      case ($urandom_range(0, 3))
        0:       inst = ($urandom() & 32'hffff_ff80) | 32'h6f;
        1:       inst = ($urandom() & 32'hffff_ff80) | 32'h63;
        2:       inst = ($urandom() & 32'hffff_ff80) | 32'h67;
        default: inst = ($urandom() & 32'hffff_ff80) | 32'h13;
      endcase
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0,
           pc, inst, $urandom_range(0, 1) == 1, rand_pc(), $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom(),
           int'($urandom_range(0, 255)), $urandom_range(0, 5) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
